// File: rtl/sa_seq_ctrl_if.sv
// rtl/sa_seq_ctrl_if.sv - job handshake and buffer/tile control bundle for sa_seq_ctrl
//
// Purpose: groups the job request/status signals and the tile/buffer control
//   outputs of the systolic tile sequencer.
// Signals:
//   start, abort, k_len        job request, cancel, activation vector count K
//   busy, done, err            job status (done/err are one-cycle pulses)
//   arr_clr_n                  active-low clear to all tile MAC cells
//   wt_rd_en, wt_rd_addr       weight buffer read port
//   act_rd_en, act_rd_addr     activation buffer read port
//   row_valid                  per-row skewed input-valid mask
//   res_capture                result-buffer latch strobe
// Modports: master = job issuer / observer, slave = sequencer.
interface sa_seq_ctrl_if #(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] k_len;
  logic              busy;
  logic              done;
  logic              err;
  logic              arr_clr_n;
  logic              wt_rd_en;
  logic [ADDR_W-1:0] wt_rd_addr;
  logic              act_rd_en;
  logic [ADDR_W-1:0] act_rd_addr;
  logic [SIZE-1:0]   row_valid;
  logic              res_capture;

  modport master (
    output start, abort, k_len,
    input  busy, done, err, arr_clr_n, wt_rd_en, wt_rd_addr,
    input  act_rd_en, act_rd_addr, row_valid, res_capture
  );

  modport slave (
    input  start, abort, k_len,
    output busy, done, err, arr_clr_n, wt_rd_en, wt_rd_addr,
    output act_rd_en, act_rd_addr, row_valid, res_capture
  );
endinterface

// File: rtl/sa_seq_ctrl.sv
// rtl/sa_seq_ctrl.sv - job sequencer for one SIZE x SIZE weight-stationary systolic tile
//
// Purpose: per job, clears the tile, streams SIZE weight words, streams K
//   activation vectors with per-row skew, waits DRAIN_CYC cycles for the
//   pipeline to empty and pulses done/res_capture. All outputs are registered.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    sa_seq_ctrl_if.slave: start/abort/k_len in; busy/done/err,
//          arr_clr_n, weight/activation read ports, row_valid, res_capture out
module sa_seq_ctrl #(
  parameter int SIZE      = 4,
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 2 * SIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  sa_seq_ctrl_if.slave  bus
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              abort_pend_q, abort_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              clr_n_q, clr_n_d;
  logic              wt_en_q, wt_en_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic              act_en_q, act_en_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic [SIZE-1:0]   row_valid_q, row_valid_d;
  logic              cap_q, cap_d;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    clr_n_d      = 1'b1;
    wt_en_d      = 1'b0;
    wt_addr_d    = wt_addr_q;
    act_en_d     = 1'b0;
    act_addr_d   = act_addr_q;
    cap_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.k_len != '0) begin
            k_d     = bus.k_len;
            state_d = CLEAR;
            clr_n_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        // CLEAR doubles as the one-cycle flush after an abort.
        if (abort_pend_q) begin
          state_d      = IDLE;
          abort_pend_d = 1'b0;
        end else begin
          state_d   = LOAD;
          wt_en_d   = 1'b1;
          wt_addr_d = '0;
        end
      end
      LOAD: begin
        if (wt_addr_q == ADDR_W'(SIZE - 1)) begin
          state_d    = STREAM;
          act_en_d   = 1'b1;
          act_addr_d = '0;
        end else begin
          wt_en_d   = 1'b1;
          wt_addr_d = wt_addr_q + 1'b1;
        end
      end
      STREAM: begin
        if (act_addr_q == k_q - 1'b1) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          act_en_d   = 1'b1;
          act_addr_d = act_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          cap_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Row 0 sees the activation enable directly; row i sees it i cycles later.
    row_valid_d = (row_valid_q << 1) | SIZE'(act_en_d);

    if (state_q != IDLE && bus.abort) begin
      state_d      = CLEAR;
      abort_pend_d = 1'b1;
      clr_n_d      = 1'b0;
      wt_en_d      = 1'b0;
      act_en_d     = 1'b0;
      wt_addr_d    = wt_addr_q;
      act_addr_d   = act_addr_q;
      done_d       = 1'b0;
      cap_d        = 1'b0;
      row_valid_d  = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      clr_n_q      <= 1'b1;
      wt_en_q      <= 1'b0;
      wt_addr_q    <= '0;
      act_en_q     <= 1'b0;
      act_addr_q   <= '0;
      row_valid_q  <= '0;
      cap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      clr_n_q      <= clr_n_d;
      wt_en_q      <= wt_en_d;
      wt_addr_q    <= wt_addr_d;
      act_en_q     <= act_en_d;
      act_addr_q   <= act_addr_d;
      row_valid_q  <= row_valid_d;
      cap_q        <= cap_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.arr_clr_n   = clr_n_q;
  assign bus.wt_rd_en    = wt_en_q;
  assign bus.wt_rd_addr  = wt_addr_q;
  assign bus.act_rd_en   = act_en_q;
  assign bus.act_rd_addr = act_addr_q;
  assign bus.row_valid   = row_valid_q;
  assign bus.res_capture = cap_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb/tb_sa_seq_ctrl.sv - directed self-checking bench for sa_seq_ctrl
module tb_sa_seq_ctrl;

  localparam int SIZE   = 4;
  localparam int ADDR_W = 8;
  localparam int DRAIN  = 2 * SIZE;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  sa_seq_ctrl_if #(.SIZE(SIZE), .ADDR_W(ADDR_W)) ifc ();

  sa_seq_ctrl #(.SIZE(SIZE), .ADDR_W(ADDR_W), .DRAIN_CYC(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, done, err, arr_clr_n, wt_en, wt_addr, act_en, act_addr, row_valid, capture}
  function automatic logic [26:0] mk(logic b, logic d, logic e, logic cl, logic we,
                                     logic [7:0] wa, logic ae, logic [7:0] aa,
                                     logic [3:0] rv, logic cp);
    return {b, d, e, cl, we, wa, ae, aa, rv, cp};
  endfunction

  function automatic logic [26:0] observe();
    return {ifc.busy, ifc.done, ifc.err, ifc.arr_clr_n, ifc.wt_rd_en, ifc.wt_rd_addr,
            ifc.act_rd_en, ifc.act_rd_addr, ifc.row_valid, ifc.res_capture};
  endfunction

  // Expected outputs in cycle c of a job started in cycle 0 with count k;
  // wt0/act0 are the addresses left over from the previous job.
  function automatic logic [26:0] model(int c, int k, logic [7:0] wt0, logic [7:0] act0);
    int         ss;
    int         dn;
    logic       we;
    logic       ae;
    logic [7:0] wa;
    logic [7:0] aa;
    logic [3:0] rv;
    ss = SIZE + 2;
    dn = SIZE + 2 + k + DRAIN;
    we = (c >= 2) && (c < ss);
    ae = (c >= ss) && (c < ss + k);
    wa = (c < 2) ? wt0 : (we ? 8'(c - 2) : 8'(SIZE - 1));
    aa = (c < ss) ? act0 : (ae ? 8'(c - ss) : 8'(k - 1));
    for (int i = 0; i < SIZE; i++) rv[i] = ((c - i) >= ss) && ((c - i) < ss + k);
    return mk((c >= 1) && (c <= dn), c == dn, 1'b0, c != 1, we, wa, ae, aa, rv, c == dn);
  endfunction

  // Sample outputs of the current cycle, then drive this cycle's inputs.
  task automatic step(input logic s, input logic a, input logic [7:0] k, output logic [26:0] obs);
    @(negedge clk);
    obs = observe();
    ifc.start = s;
    ifc.abort = a;
    ifc.k_len = k;
  endtask

  task automatic test_reset();
    logic [26:0] obs;
    rst_n = 1'b0;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.k_len = '0;
    repeat (3) @(negedge clk);
    obs = observe();
    n_cmp++;
    if (obs !== mk(0, 0, 0, 1, 0, 8'd0, 0, 8'd0, 4'd0, 0)) begin
      n_bad++;
      $display("FAIL reset_values got=%h exp=%h", obs, mk(0, 0, 0, 1, 0, 8'd0, 0, 8'd0, 4'd0, 0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reject();
    logic [26:0] obs;
    for (int c = 0; c < 5; c++) begin
      step(c == 0, 1'b0, 8'd0, obs);
      n_cmp++;
      if (obs !== mk(0, 0, c == 1, 1, 0, 8'd0, 0, 8'd0, 4'd0, 0)) begin
        n_bad++;
        $display("FAIL reject cyc=%0d got=%h exp=%h", c, obs, mk(0, 0, c == 1, 1, 0, 8'd0, 0, 8'd0, 4'd0, 0));
      end
    end
  endtask

  task automatic test_basic();
    logic [26:0] obs;
    for (int c = 0; c < 25; c++) begin
      step(c == 0, 1'b0, 8'd5, obs);
      n_cmp++;
      if (obs !== model(c, 5, 8'd0, 8'd0)) begin
        n_bad++;
        $display("FAIL basic_k5 cyc=%0d got=%h exp=%h", c, obs, model(c, 5, 8'd0, 8'd0));
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [26:0] obs;
    for (int c = 0; c < 25; c++) begin
      step((c == 0) || (c == 4), 1'b0, 8'd5, obs);
      n_cmp++;
      if (obs !== model(c, 5, 8'd3, 8'd4)) begin
        n_bad++;
        $display("FAIL start_busy cyc=%0d got=%h exp=%h", c, obs, model(c, 5, 8'd3, 8'd4));
      end
    end
  endtask

  task automatic test_abort();
    logic [26:0] obs;
    logic [26:0] exp;
    for (int c = 0; c < 26; c++) begin
      step(c == 0, c == 8, 8'd5, obs);
      if (c <= 8)       exp = model(c, 5, 8'd3, 8'd4);
      else if (c == 9)  exp = mk(1, 0, 0, 0, 0, 8'd3, 0, 8'd2, 4'd0, 0);
      else              exp = mk(0, 0, 0, 1, 0, 8'd3, 0, 8'd2, 4'd0, 0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL abort_stream cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] obs;
    logic [26:0] exp;
    for (int c = 0; c < 33; c++) begin
      step((c == 0) || (c == 16), 1'b0, 8'd1, obs);
      exp = (c < 16) ? model(c, 1, 8'd3, 8'd2) : model(c - 16, 1, 8'd3, 8'd0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    logic [26:0] obs;
    for (int c = 0; c < 14; c++) begin
      step(c == 0, 1'b0, 8'd5, obs);
      n_cmp++;
      if (obs !== model(c, 5, 8'd3, 8'd0)) begin
        n_bad++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, obs, model(c, 5, 8'd3, 8'd0));
      end
    end
    ifc.start = 1'b0;
    #2 rst_n = 1'b0;
    #1 obs = observe();
    n_cmp++;
    if (obs !== mk(0, 0, 0, 1, 0, 8'd0, 0, 8'd0, 4'd0, 0)) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=%h", obs, mk(0, 0, 0, 1, 0, 8'd0, 0, 8'd0, 4'd0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 21; c++) begin
      step(c == 0, 1'b0, 8'd2, obs);
      n_cmp++;
      if (obs !== model(c, 2, 8'd0, 8'd0)) begin
        n_bad++;
        $display("FAIL post_reset_k2 cyc=%0d got=%h exp=%h", c, obs, model(c, 2, 8'd0, 8'd0));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_reject();
    test_basic();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sa_seq_ctrl.md
Name: sa_seq_ctrl

Overview:
- Sequencer for one SIZE x SIZE weight-stationary systolic tile built from MAC cells.
- The MAC cells accumulate continuously and clear only on their reset, so this block owns the tile clear.
- Per job it clears the tile, streams SIZE weight words, then streams K activation vectors with per-row skew.
- It then waits for the pipeline to drain and pulses a capture strobe so the result buffer latches the accumulators.

Parameters:
- SIZE, 4: tile rows/columns; sets row skew and drain length.
- ADDR_W, 8: width of buffer read addresses and of k_len.
- DRAIN_CYC, 2*SIZE: cycles held in DRAIN after the last activation issue.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  cancel the current job; sampled in any non-IDLE state.
- k_len  in  ADDR_W  activation vector count K; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse at job completion.
- err  out  1  one-cycle pulse when start is rejected.
- arr_clr_n  out  1  active-low clear to all tile MAC resets.
- wt_rd_en  out  1  weight buffer read enable.
- wt_rd_addr  out  ADDR_W  weight buffer address.
- act_rd_en  out  1  activation buffer read enable.
- act_rd_addr  out  ADDR_W  activation buffer address.
- row_valid  out  SIZE  per-row input-valid mask; the feeder drives 0 into row i when row_valid[i]=0.
- res_capture  out  1  result-buffer latch strobe.

Behaviour:
- All outputs are registered (Moore).
- Reset values: busy=0, done=0, err=0, arr_clr_n=1, wt_rd_en=0, wt_rd_addr=0, act_rd_en=0, act_rd_addr=0, row_valid=0, res_capture=0, state=IDLE.
- States: IDLE, CLEAR, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 with k_len!=0: latch K, go to CLEAR.
  - start=1 with k_len==0: err=1 for the next cycle, stay in IDLE.
- CLEAR (1 cycle): arr_clr_n=0; then go to LOAD.
- LOAD (SIZE cycles): wt_rd_en=1, wt_rd_addr=0..SIZE-1 in order; then go to STREAM.
- STREAM (K cycles): act_rd_en=1, act_rd_addr=0..K-1; then go to DRAIN.
- Skew: row_valid[0] equals act_rd_en. row_valid[i] is act_rd_en delayed i cycles through a shift register.
  - The shift register keeps shifting in DRAIN with 0 input.
  - It clears on abort and on reset.
- DRAIN (DRAIN_CYC cycles): all read enables 0; then go to DONE.
- DONE (1 cycle): done=1, res_capture=1, busy=1; then go to IDLE.
- Cycle timing, with start high in cycle 0:
  - CLEAR at cycle 1.
  - LOAD at cycles 2..SIZE+1.
  - STREAM at cycles SIZE+2..SIZE+1+K.
  - DRAIN for the following DRAIN_CYC cycles.
  - DONE at cycle SIZE+2+K+DRAIN_CYC.
- Addresses hold their last value when enables drop. They return to 0 on entering LOAD or STREAM.
- Counters are ADDR_W wide with no wrap: K is at most 2^ADDR_W-1, and the last address issued is K-1.
- start while busy: ignored, no err.
- abort in any non-IDLE state:
  - Next cycle: arr_clr_n=0, all enables and row_valid=0, done=0, res_capture=0.
  - The cycle after that: state=IDLE, busy=0.
  - abort has priority over all state transitions. start in the same cycle as abort is ignored.
- rst_n low mid-job: immediate return to reset values. No done or res_capture is produced for that job.

Test Plan:
- Basic job, SIZE=4, K=5, start at cycle 0:
  - arr_clr_n=0 at cycle 1.
  - wt_rd_en at 2..5 with addr 0,1,2,3.
  - act_rd_en at 6..10 with addr 0..4.
  - row_valid[3] high at 9..13.
  - done=res_capture=1 at cycle 19 only; busy high 1..19.
- Reject: start with k_len=0 in IDLE -> err=1 for exactly one cycle, busy stays 0, arr_clr_n stays 1.
- Start while busy: start at cycles 0 and 4 with K=5 -> a single job with timing identical to the basic job; err stays 0.
- Abort in STREAM at cycle 8 -> cycle 9: arr_clr_n=0 and row_valid=0000; cycle 10: busy=0; done never asserted.
- Back-to-back: K=1 job, then start in the cycle after done -> second CLEAR occurs exactly 1 cycle after the second start; the second job's timing matches the first.
- Reset mid-job: rst_n low during DRAIN -> all outputs take reset values asynchronously; after release, a start with K=2 gives done at cycle 16.
